// File: rtl/gmii_tx_framer_if.sv
// rtl/gmii_tx_framer_if.sv - byte stream from the transmit FIFO into the GMII framer
interface gmii_tx_framer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/gmii_tx_framer.sv
// rtl/gmii_tx_framer.sv - GMII TX framer: preamble/SFD, padding, IFG; inline FCS when GMII_TX_FCS_EN is defined
module gmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_LEN      = 60,
  parameter int IFG_LEN      = 12
) (
  input  logic              phy_gtx_clk,
  input  logic              sys_rst_n,
  gmii_tx_framer_if.slave   s_if,
  output logic              phy_tx_en,
  output logic              phy_tx_er,
  output logic [7:0]        phy_txd,
  output logic              tx_busy,
  output logic              underrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PAD  = 3'd3;
  localparam logic [2:0] S_IFG  = 3'd5;
`ifdef GMII_TX_FCS_EN
  localparam logic [2:0] S_FCS  = 3'd4;
  // state that follows the last payload/pad byte
  localparam logic [2:0] S_POST = S_FCS;
`else
  localparam logic [2:0] S_POST = S_IFG;
`endif

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_LEN - 1);
  localparam logic [11:0] MIN_L    = 12'(MIN_LEN);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic        underrun_q, underrun_d;

  logic [10:0] byte_inc;
  logic        pad_more;

`ifdef GMII_TX_FCS_EN
  logic [31:0] crc_q, crc_d;

  // one byte of the reflected CRC-32, LSB first
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction
`endif

  // byte counter saturates at 2047; padding decision uses the unsaturated next count
  assign byte_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
  assign pad_more = ({1'b0, byte_cnt_q} + 12'd1) < MIN_L;

  // next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    txd_d      = txd_q;
    tx_en_d    = tx_en_q;
    tx_er_d    = 1'b0;
    underrun_d = 1'b0;
`ifdef GMII_TX_FCS_EN
    crc_d      = crc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (s_if.in_valid) begin
          state_d = S_PRE;
          cnt_d   = 8'd0;
          txd_d   = 8'h55;
          tx_en_d = 1'b1;
        end else begin
          txd_d   = 8'h00;
          tx_en_d = 1'b0;
        end
      end
      S_PRE: begin
        cnt_d   = cnt_q + 8'd1;
        tx_en_d = 1'b1;
        if (cnt_q == PRE_LAST) begin
          txd_d      = 8'hD5;
          byte_cnt_d = 11'd0;
          state_d    = S_DATA;
`ifdef GMII_TX_FCS_EN
          crc_d      = 32'hFFFFFFFF;
`endif
        end else begin
          txd_d = 8'h55;
        end
      end
      S_DATA: begin
        tx_en_d = 1'b1;
        if (s_if.in_valid) begin
          txd_d      = s_if.in_data;
          byte_cnt_d = byte_inc;
`ifdef GMII_TX_FCS_EN
          crc_d      = crc_byte(crc_q, s_if.in_data);
`endif
          if (s_if.in_last) begin
            cnt_d   = 8'd0;
            state_d = pad_more ? S_PAD : S_POST;
          end
        end else begin
          // source starved mid-frame: poison the frame and back off
          tx_er_d    = 1'b1;
          txd_d      = 8'h00;
          underrun_d = 1'b1;
          cnt_d      = 8'd0;
          state_d    = S_IFG;
        end
      end
      S_PAD: begin
        tx_en_d    = 1'b1;
        txd_d      = 8'h00;
        byte_cnt_d = byte_inc;
`ifdef GMII_TX_FCS_EN
        crc_d      = crc_byte(crc_q, 8'h00);
`endif
        if (!pad_more) begin
          cnt_d   = 8'd0;
          state_d = S_POST;
        end
      end
`ifdef GMII_TX_FCS_EN
      S_FCS: begin
        tx_en_d = 1'b1;
        case (cnt_q[1:0])
          2'd0:    txd_d = ~crc_q[7:0];
          2'd1:    txd_d = ~crc_q[15:8];
          2'd2:    txd_d = ~crc_q[23:16];
          default: txd_d = ~crc_q[31:24];
        endcase
        cnt_d = cnt_q + 8'd1;
        if (cnt_q[1:0] == 2'd3) begin
          cnt_d   = 8'd0;
          state_d = S_IFG;
        end
      end
`endif
      S_IFG: begin
        tx_en_d = 1'b0;
        txd_d   = 8'h00;
        cnt_d   = cnt_q + 8'd1;
        if (cnt_q == IFG_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_en_d = 1'b0;
        txd_d   = 8'h00;
      end
    endcase
  end

  // state and PHY pin registers, cleared asynchronously
  always_ff @(posedge phy_gtx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      byte_cnt_q <= 11'd0;
      txd_q      <= 8'h00;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      underrun_q <= 1'b0;
`ifdef GMII_TX_FCS_EN
      crc_q      <= 32'hFFFFFFFF;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      txd_q      <= txd_d;
      tx_en_q    <= tx_en_d;
      tx_er_q    <= tx_er_d;
      underrun_q <= underrun_d;
`ifdef GMII_TX_FCS_EN
      crc_q      <= crc_d;
`endif
    end
  end

  assign s_if.in_ready = (state_q == S_DATA);
  assign tx_busy       = (state_q != S_IDLE);
  assign phy_tx_en     = tx_en_q;
  assign phy_tx_er     = tx_er_q;
  assign phy_txd       = txd_q;
  assign underrun      = underrun_q;

endmodule

// File: doc/gmii_tx_framer.md
# gmii_tx_framer

Parametrised GMII transmit framer that turns a byte stream into Ethernet frames on the PHY side, all in the `phy_gtx_clk` domain. It sits between the transmit FIFO read port and the PHY pins. It adds a configurable preamble and SFD, zero padding up to a minimum length, an inline CRC-32 FCS, and an enforced inter-frame gap. Unlike the previous generation, it also signals mid-frame underrun on `phy_tx_er`.

## Interface
- `PREAMBLE_LEN`, default 7: number of 0x55 bytes before the SFD; legal range 1–15.
- `MIN_LEN`, default 60: minimum payload byte count before the FCS, after padding; 0 disables padding; max 2047.
- `IFG_LEN`, default 12: idle cycles forced after each frame or abort; legal range 1–255.
- `phy_gtx_clk` in 1: the single 125 MHz clock.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: source has a byte on `in_data`.
- `in_data` in 8: payload byte (destination MAC onward).
- `in_last` in 1: qualifies the final payload byte of a frame.
- `in_ready` out 1: framer accepts a byte this cycle.
- `phy_tx_en` out 1: GMII TX_EN.
- `phy_tx_er` out 1: GMII TX_ER.
- `phy_txd` out 8: GMII TXD.
- `tx_busy` out 1: high in any state other than IDLE.
- `underrun` out 1: one-cycle pulse when a frame is aborted.

## Operation
- States: IDLE, PRE, DATA, PAD, FCS, IFG. All PHY outputs are registered.
- **IDLE**
  - `in_valid`=1 → PRE and preamble counter=0; register `phy_txd`=0x55, `phy_tx_en`=1.
  - Otherwise `phy_tx_en`=0 and `phy_txd`=0.
  - `in_valid` is only sampled here; no byte is consumed.
- **PRE**
  - Counter increments each cycle.
  - While counter < `PREAMBLE_LEN`-1, load 0x55.
  - At counter = `PREAMBLE_LEN`-1, load 0xD5, reset the CRC to 0xFFFFFFFF and the byte counter to 0, then go to DATA.
- **DATA**
  - `in_ready` = (state==DATA), a combinational decode.
  - On `in_valid`: load `in_data` into `phy_txd`, update the CRC with it, and increment the byte counter. The byte counter is 11-bit and saturates at 2047.
  - When `in_last` is accepted:
    - byte counter+1 < `MIN_LEN` → PAD;
    - otherwise → FCS, or IFG if the FCS is compiled out.
  - `in_valid`=0 in DATA is an underrun:
    - load `phy_tx_er`=1, `phy_tx_en`=1, `phy_txd`=0 for one cycle;
    - pulse `underrun`;
    - go to IFG.
  - The source then discards the rest of that frame, up to and including `in_last`.
- **PAD**
  - Load 0x00 and update the CRC each cycle until the byte counter reaches `MIN_LEN`.
  - Then go to FCS, or IFG if the FCS is compiled out.
- **FCS**
  - Send ~crc[7:0], ~crc[15:8], ~crc[23:16], ~crc[31:24], in that order.
  - The CRC is the reflected IEEE 802.3 CRC-32 (polynomial 0xEDB88320, LSB-first), computed over payload and pad bytes. It excludes preamble and SFD.
  - Then go to IFG.
- **IFG**
  - `phy_tx_en`=0 and `phy_tx_er`=0 for `IFG_LEN` cycles, then IDLE.
  - `in_ready` is 0 and `in_valid` is ignored.
- Reset assertion in any state, including mid-frame, asynchronously forces:
  - state IDLE;
  - `phy_tx_en`=0, `phy_tx_er`=0, `phy_txd`=0x00;
  - `underrun`=0, `tx_busy`=0, `in_ready`=0;
  - all counters 0 and CRC 0xFFFFFFFF.
- Release of `sys_rst_n` is assumed to be synchronised externally.

## Timing
- Start latency: `in_valid` sampled high in IDLE at edge N → first 0x55 on the pins after N.
- The SFD is on the pins during the first DATA cycle.
- The byte accepted at edge M appears on `phy_txd` after M, so data is contiguous with no bubble after the SFD.
- `phy_tx_en` high time per frame = `PREAMBLE_LEN` + 1 + max(payload, `MIN_LEN`) + 4 cycles, with the FCS compiled in.
- Earliest next preamble is `IFG_LEN` cycles after `phy_tx_en` falls.
- A frame of length 1 with `in_last` is legal and is padded.
- A byte presented with `in_last` in the same cycle as an underrun cannot occur: acceptance requires `in_valid`.

## Configuration
- `GMII_TX_FCS_EN`
  - Defined: FCS state and CRC logic are built, and 4 FCS bytes are appended.
  - Undefined: no CRC logic; after the last DATA/PAD byte the framer goes directly to IFG, and the caller supplies the FCS in the stream.

## Test plan
- **Basic frame.** Defaults, FCS enabled, 60 payload bytes 0x00..0x3B with no gaps.
  - Required: 7×0x55, 0xD5, the 60 bytes in order, then 4 FCS bytes matching a software CRC-32.
  - `phy_tx_en` high for exactly 72 cycles.
- **CRC check value.** `MIN_LEN`=0, payload ASCII "123456789".
  - FCS bytes must be 0x26, 0x39, 0xF4, 0xCB.
- **Padding.** 10-byte payload with defaults.
  - 50 bytes of 0x00 follow the payload, then the FCS over all 60 bytes.
  - `phy_tx_en` high for 72 cycles.
- **Underrun.** Drop `in_valid` after the 20th payload byte.
  - Next cycle: `phy_tx_er`=1, `phy_tx_en`=1, `phy_txd`=0x00, and `underrun` pulses.
  - Then 12 idle cycles, with `in_ready`=0 throughout.
- **Back-to-back frames.** Keep `in_valid` high across two frames.
  - Exactly `IFG_LEN`=12 low cycles of `phy_tx_en` between the frames.
  - `PREAMBLE_LEN`=3 run: 3×0x55 then 0xD5.
- **Mid-frame reset.** Assert `sys_rst_n`=0 during the FCS.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, a new frame starts cleanly with its CRC reinitialised.
